input_conditioner: RTL

Front-end conditioning stage for the board's switch and push-button inputs, directly upstream of the data memory's memory-mapped input word and button flag. It synchronises the 18 slide switches, debounces the raw active-low enter key with a state machine, and latches the switch value on each confirmed press. It holds a pending-input flag until the processor side acknowledges it. Its `in` and `bin` outputs connect straight to the memory's `in` and `bin` inputs.

---
 rtl/input_conditioner.sv | 122 ++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Switch/enter-key front end: synchronises the switches and the active-low key,
// debounces the key and latches the switch word with a pending flag per confirmed press.
//
// state | meaning
// IDLE  | key released and settled, waiting for a press
// DOWN  | key seen pressed, timing the stable-low interval
// HELD  | press confirmed and captured, waiting for release
// UP    | key seen released, timing the stable-high interval
module input_conditioner #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             key,
    input  logic             ack,
    output logic [WIDTH-1:0] in,
    output logic             bin,
    output logic             press,
    output logic             overrun
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The entry edge into DOWN/UP is the first of the DEBOUNCE_CYCLES stable samples,
    // so the counter only has to cover the remaining DEBOUNCE_CYCLES-1 edges.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        HELD = 2'd2,
        UP   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sw_m;
    logic [WIDTH-1:0] sw_s;
    logic             key_m;
    logic             key_s;
    logic             capture;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_m  <= '0;
            sw_s  <= '0;
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            key_m <= key;
            key_s <= key_m;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt <= '0;
            end else if (state_q == DOWN || state_q == UP) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) state_d = DOWN;
            end
            DOWN: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_d = HELD;
                    capture = 1'b1;
                end
            end
            HELD: begin
                if (key_s) state_d = UP;
            end
            UP: begin
                if (!key_s) begin
                    state_d = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture coinciding with ack means the old value was consumed: no overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in      <= '0;
            bin     <= 1'b0;
            press   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            press <= capture;
            if (capture) begin
                in  <= sw_s;
                bin <= 1'b1;
                if (bin && !ack) overrun <= 1'b1;
            end else if (ack) begin
                bin     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
